ps2_key_buffer: RTL and testbench
=================================

# ps2_key_buffer

Parametrised PS/2 keystroke capture buffer, the next-generation player input stage. Samples a raw PS/2 clock/data pair in the system clock domain, decodes 11-bit frames with parity and stop-bit checking, and stores accepted scan codes in a circular buffer of configurable depth. Replaces the bare write-address counter with a first-word-fall-through read port, occupancy count, overflow/error reporting and a frame watchdog, so game logic can consume keystrokes at its own pace.

## Interface
- DEPTH, 16, buffer entries; power of two, 2..256
- ADDR_W, $clog2(DEPTH), pointer width (derived)
- SYNC_STAGES, 2, synchroniser flops on ps2_clock/ps2_data; minimum 2
- TIMEOUT_CYCLES, 50000, system clocks without a PS/2 falling edge before a partial frame is aborted

- clock  in  1  system clock; single clock domain
- resetn  in  1  asynchronous, active-low reset
- ps2_clock  in  1  raw PS/2 clock, asynchronous to clock
- ps2_data  in  1  raw PS/2 data, asynchronous to clock
- clear  in  1  synchronous flush: empties buffer, clears sticky flags, aborts receiver
- rd_en  in  1  pop oldest entry; ignored when empty
- rd_data  out  8  oldest stored scan code; valid while !empty
- empty  out  1  buffer holds no entries
- full  out  1  count == DEPTH
- count  out  ADDR_W+1  occupancy, 0..DEPTH
- wr_addr  out  ADDR_W  next write slot
- overflow  out  1  sticky: a good frame arrived while full
- frame_err  out  1  sticky: parity, start/stop or timeout error seen

## Operation
- Both PS/2 inputs pass through SYNC_STAGES flops, reset to 1; falling edge of synced ps2_clock = one extra flop comparison.
- Receiver FSM, one transition per falling edge: IDLE -> DATA (if sampled start bit = 0; a 1 stays in IDLE, no error) -> DATA x8, LSB first -> PARITY -> STOP -> IDLE.
- Parity odd over 8 data bits + parity bit; stop bit must be 1. Any violation: byte discarded, frame_err set, FSM to IDLE.
- Watchdog counter reloads on every falling edge; in any state other than IDLE, reaching TIMEOUT_CYCLES returns FSM to IDLE and sets frame_err.
- Good frame: pushed at wr_addr; wr_addr increments mod DEPTH (wraps DEPTH-1 -> 0). If full and no pop in the same cycle: byte dropped, overflow set, pointers unchanged.
- Push and pop in the same cycle: both performed, count unchanged; valid at full (drops nothing) and not applicable at empty (pop ignored, push proceeds).
- rd_data is FWFT: shows the entry at read pointer combinationally from storage; after pop, shows next entry the following cycle.
- clear has priority over push/pop in its cycle; holds FSM in IDLE while asserted.
- Reset values: rd_data 0, empty 1, full 0, count 0, wr_addr 0, overflow 0, frame_err 0, FSM IDLE, watchdog 0.
- Reset or clear mid-frame: partial frame discarded; next frame decoded normally from its start bit.

## Timing
- Raw ps2_clock fall to edge detect: SYNC_STAGES+1 clocks.
- Edge on stop bit to push: 1 clock (FSM registers result, storage written on that edge); empty falls and count increments the same edge.
- rd_en high with !empty: count decrements, read pointer advances on that edge; rd_data updates immediately after.
- Sticky flags set 1 clock after the causing event; cleared only by resetn or clear.

## Configuration
- PS2_BREAK_FILTER_EN defined: a received 0xF0 is not stored and arms a one-byte discard; the next good byte is also dropped (release events suppressed). 0xE0 prefixes are stored. clear/reset disarms. Error frames do not disarm.
- Undefined: every good byte, including 0xF0, is stored.

## Structure
- Shared package ps2_pkg: FSM state enum (IDLE, DATA, PARITY, STOP), constants PS2_BREAK_CODE = 8'hF0, PS2_EXT_CODE = 8'hE0, frame bit count 11.
- One sub-module: ps2_rx_frame (synchroniser, edge detect, FSM, watchdog, parity); outputs 1-cycle byte_valid, byte, byte_err. Top holds storage, pointers, flags, filter.

## Test plan
- Send frame 0x1C (parity 0, stop 1) -> 5 clocks after stop edge, empty=0, count=1, rd_data=0x1C, wr_addr=1; pop -> empty=1.
- DEPTH=4: send 0x15,0x1D,0x24,0x2D,0x2C without reads -> full=1, count=4, overflow=1, reads return 0x15,0x1D,0x24,0x2D; wr_addr wrapped to 0.
- Frame 0x1C with wrong parity bit -> nothing stored, frame_err=1; following good 0x1B stored.
- Stop after 5 data bits, idle TIMEOUT_CYCLES+1 clocks -> FSM IDLE, frame_err=1, count=0; next full frame 0x23 stored.
- Full buffer, rd_en asserted in the push cycle of 0x4B -> count stays 4, overflow=0, 0x4B read last.
- With PS2_BREAK_FILTER_EN: send 0x1C,0xF0,0x1C,0xE0,0x75 -> stored 0x1C,0xE0,0x75; without: all five stored.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared receiver state encoding and PS/2 protocol constants.
package ps2_pkg;

  // Receiver states; the localparam copies keep the FSM code in plain logic vectors.
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_DATA   = 2'(DATA);
  localparam logic [1:0] ST_PARITY = 2'(PARITY);
  localparam logic [1:0] ST_STOP   = 2'(STOP);

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronises the raw PS/2 pair, detects falling clock edges,
// decodes 11-bit frames (start, 8 data LSB first, odd parity, stop) and
// aborts stalled frames with a watchdog. Emits one-cycle byte_valid/byte_err.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  input  logic       clear,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       byte_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   clk_prev_reg;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  logic [1:0]      state_reg;
  logic [2:0]      bit_cnt_reg;
  logic [7:0]      shift_reg;
  logic            parity_reg;
  logic [WD_W-1:0] wd_reg;
  logic            byte_valid_reg;
  logic            byte_err_reg;

  // Synchroniser chains idle high like the PS/2 bus; one extra flop for edge detect.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync_reg  <= '1;
      data_sync_reg <= '1;
      clk_prev_reg  <= 1'b1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clock};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
      clk_prev_reg  <= clk_s;
    end
  end

  assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
  assign data_s = data_sync_reg[SYNC_STAGES-1];
  assign fall   = clk_prev_reg & ~clk_s;

  // Frame FSM advancing once per falling edge, with a watchdog for stalled frames.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'd0;
      parity_reg     <= 1'b0;
      wd_reg         <= '0;
      byte_valid_reg <= 1'b0;
      byte_err_reg   <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      byte_err_reg   <= 1'b0;
      if (clear) begin
        state_reg   <= ST_IDLE;
        bit_cnt_reg <= 3'd0;
        wd_reg      <= '0;
      end else if (fall) begin
        wd_reg <= '0;
        case (state_reg)
          ST_IDLE: begin
            // A high start bit is line noise: stay idle without flagging it.
            if (!data_s) begin
              state_reg   <= ST_DATA;
              bit_cnt_reg <= 3'd0;
            end
          end
          ST_DATA: begin
            shift_reg   <= {data_s, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_reg <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_reg <= data_s;
            state_reg  <= ST_STOP;
          end
          ST_STOP: begin
            state_reg <= ST_IDLE;
            if (data_s && ((^shift_reg) ^ parity_reg)) byte_valid_reg <= 1'b1;
            else                                       byte_err_reg   <= 1'b1;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end else if (state_reg != ST_IDLE) begin
        if (wd_reg == WD_LAST) begin
          state_reg    <= ST_IDLE;
          wd_reg       <= '0;
          byte_err_reg <= 1'b1;
        end else begin
          wd_reg <= wd_reg + 1'b1;
        end
      end
    end
  end

  assign byte_valid = byte_valid_reg;
  assign byte_err   = byte_err_reg;
  assign rx_byte    = shift_reg;

endmodule

// File: rtl/ps2_key_buffer.sv
// ps2_key_buffer: PS/2 keystroke capture into a FWFT circular buffer with
// occupancy, sticky overflow/frame-error flags and a synchronous flush.
// Optional macro PS2_BREAK_FILTER_EN: drop 0xF0 and the byte following it.
module ps2_key_buffer
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              ps2_clock,
  input  logic              ps2_data,
  input  logic              clear,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              overflow,
  output logic              frame_err
);

  logic       rx_byte_valid;
  logic [7:0] rx_byte;
  logic       rx_byte_err;

  ps2_rx_frame #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock     (clock),
    .resetn    (resetn),
    .ps2_clock (ps2_clock),
    .ps2_data  (ps2_data),
    .clear     (clear),
    .byte_valid(rx_byte_valid),
    .rx_byte   (rx_byte),
    .byte_err  (rx_byte_err)
  );

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              overflow_reg;
  logic              frame_err_reg;
  logic              push_req;
  logic              pop;
  logic              push_ok;

`ifdef PS2_BREAK_FILTER_EN
  logic discard_armed_reg;

  // Break prefix arms a one-byte discard; the following good byte disarms it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                 discard_armed_reg <= 1'b0;
    else if (clear)              discard_armed_reg <= 1'b0;
    else if (rx_byte_valid) begin
      if (discard_armed_reg)     discard_armed_reg <= 1'b0;
      else if (rx_byte == PS2_BREAK_CODE) discard_armed_reg <= 1'b1;
    end
  end

  assign push_req = rx_byte_valid && !discard_armed_reg && (rx_byte != PS2_BREAK_CODE);
`else
  assign push_req = rx_byte_valid;
`endif

  assign full    = (count_reg == (ADDR_W + 1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign pop     = rd_en && !empty && !clear;
  assign push_ok = push_req && (!full || pop) && !clear;

  // Storage write port; no reset so it maps onto RAM.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_reg] <= rx_byte;
  end

  // Pointers, occupancy and sticky flags; clear overrides push/pop.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push_ok) count_reg <= count_reg - 1'b1;
      if (push_req && full && !pop) overflow_reg  <= 1'b1;
      if (rx_byte_err)              frame_err_reg <= 1'b1;
    end
  end

  assign rd_data   = empty ? 8'd0 : mem[rd_ptr_reg];
  assign count     = count_reg;
  assign wr_addr   = wr_ptr_reg;
  assign overflow  = overflow_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_key_buffer.sv
// tb_ps2_key_buffer: directed PS/2 frames against a queue-based scoreboard.
module tb_ps2_key_buffer;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 200;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              ps2_clock = 1'b1;
  logic              ps2_data = 1'b1;
  logic              clear = 1'b0;
  logic              rd_en = 1'b0;
  logic [7:0]        rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] wr_addr;
  logic              overflow;
  logic              frame_err;

  ps2_key_buffer #(
    .DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock(clock), .resetn(resetn), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
    .clear(clear), .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .wr_addr(wr_addr), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int fail_cnt  = 0;

  // Scoreboard model
  logic [7:0] q[$];
  int         m_wr = 0;
  logic       m_ovf = 1'b0;
  logic       m_err = 1'b0;
  logic       m_armed = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_good(input logic [7:0] b);
`ifdef PS2_BREAK_FILTER_EN
    if (m_armed) begin m_armed = 1'b0; return; end
    if (b == 8'hF0) begin m_armed = 1'b1; return; end
`endif
    if (q.size() == DEPTH) m_ovf = 1'b1;
    else begin
      q.push_back(b);
      m_wr = (m_wr + 1) % DEPTH;
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge clock) ps2_data = v;
    repeat (5) @(negedge clock);
    ps2_clock = 1'b0;
    repeat (10) @(negedge clock);
    ps2_clock = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  // nbits < 8 truncates the frame after that many data bits
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int nbits);
    logic [10:0] f;
    int n;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    n = (nbits >= 8) ? 11 : 1 + nbits;
    for (int i = 0; i < n; i++) send_bit(f[i]);
    ps2_data = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), 32'(q.size()));
    check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'(m_wr));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(m_err));
    check({tag, "_rd_data"}, 32'(rd_data), (q.size() == 0) ? 32'd0 : 32'(q[0]));
    $display("[TB] %s: count=%0d rd_data=0x%02h ovf=%0b err=%0b", tag, count, rd_data,
             overflow, frame_err);
  endtask

  task automatic pop_check(input string tag);
    check(tag, 32'(rd_data), (q.size() == 0) ? 32'd0 : 32'(q[0]));
    $display("[TB] pop %s: rd_data=0x%02h", tag, rd_data);
    rd_en = 1'b1;
    @(negedge clock) rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic do_clear();
    @(negedge clock) clear = 1'b1;
    @(negedge clock) clear = 1'b0;
    q.delete();
    m_wr = 0; m_ovf = 1'b0; m_err = 1'b0; m_armed = 1'b0;
  endtask

  initial begin
    logic [7:0] seq5 [5];
    logic       seen;

    // Reset state
    repeat (3) @(negedge clock);
    check_status("reset_held");
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check_status("reset_released");

    // Single frame then pop
    send_frame(8'h1C, 1'b0, 1'b0, 8);
    model_good(8'h1C);
    check_status("single_1C");
    pop_check("single_pop");
    check_status("single_after_pop");

    // Fill past depth, wrap, overflow
    do_clear();
    check_status("after_clear");
    seq5 = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    for (int i = 0; i < 5; i++) begin
      send_frame(seq5[i], 1'b0, 1'b0, 8);
      model_good(seq5[i]);
    end
    check_status("overflow_full");
    for (int i = 0; i < DEPTH; i++) pop_check("overflow_read");
    check_status("overflow_drained");

    // Parity error, then good byte
    do_clear();
    send_frame(8'h1C, 1'b1, 1'b0, 8);
    m_err = 1'b1;
    check_status("bad_parity");
    send_frame(8'h1B, 1'b0, 1'b0, 8);
    model_good(8'h1B);
    check_status("after_bad_parity");
    pop_check("after_bad_parity_pop");

    // Stop bit error
    do_clear();
    send_frame(8'h42, 1'b0, 1'b1, 8);
    m_err = 1'b1;
    check_status("bad_stop");

    // Watchdog abort after 5 data bits
    do_clear();
    send_frame(8'h23, 1'b0, 1'b0, 5);
    repeat (TIMEOUT + 1) @(negedge clock);
    m_err = 1'b1;
    check_status("timeout");
    send_frame(8'h23, 1'b0, 1'b0, 8);
    model_good(8'h23);
    check_status("after_timeout");

    // Simultaneous push and pop at full
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 8);
      model_good(8'h10 + 8'(i));
    end
    check_status("full_before_rw");
    seen = 1'b0;
    fork
      send_frame(8'h4B, 1'b0, 1'b0, 8);
      begin
        for (int k = 0; k < 1000 && !seen; k++) begin
          @(negedge clock);
          if (dut.rx_byte_valid) seen = 1'b1;
        end
        if (seen) begin
          check("rw_same_cycle_rd_data", 32'(rd_data), 32'(q[0]));
          rd_en = 1'b1;
          @(negedge clock) rd_en = 1'b0;
          void'(q.pop_front());
          model_good(8'h4B);
        end
      end
    join
    check("rw_push_window_seen", 32'(seen), 32'd1);
    check_status("full_after_rw");
    for (int i = 0; i < DEPTH; i++) pop_check("rw_read");

    // Break-code sequence
    do_clear();
    seq5 = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75};
    for (int i = 0; i < 5; i++) begin
      send_frame(seq5[i], 1'b0, 1'b0, 8);
      model_good(seq5[i]);
    end
    check_status("break_seq");
    while (q.size() != 0) pop_check("break_read");
    check_status("break_drained");

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
